// File: rtl/control_unit.sv
// Hardwired Moore control sequencer: fetch in T0..T2, opcode-dependent execute in T3..T7,
// and a HALT state that only Reset can leave.
module control_unit #(
  parameter logic [4:0] ADD_OP = 5'b00011
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IRregister,
  input  logic        CON,
  output logic        PCin,
  output logic        MDRin,
  output logic        Zin,
  output logic        Yin,
  output logic        MARin,
  output logic        IRin,
  output logic        CONin,
  output logic        Rin,
  output logic        HIin,
  output logic        LOin,
  output logic        OUTPORTin,
  output logic        PCout,
  output logic        MDRout,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIout,
  output logic        LOout,
  output logic        INPORTout,
  output logic        Cout,
  output logic        Rout,
  output logic        BAout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Read,
  output logic        write,
  output logic        IncPC,
  output logic [4:0]  AluOp,
  output logic        Run
);

  typedef enum logic [3:0] {
    T0   = 4'd0,
    T1   = 4'd1,
    T2   = 4'd2,
    T3   = 4'd3,
    T4   = 4'd4,
    T5   = 4'd5,
    T6   = 4'd6,
    T7   = 4'd7,
    HALT = 4'd8
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int B_PCIN      = 0;
  localparam int B_MDRIN     = 1;
  localparam int B_ZIN       = 2;
  localparam int B_YIN       = 3;
  localparam int B_MARIN     = 4;
  localparam int B_IRIN      = 5;
  localparam int B_CONIN     = 6;
  localparam int B_RIN       = 7;
  localparam int B_HIIN      = 8;
  localparam int B_LOIN      = 9;
  localparam int B_OUTPORTIN = 10;
  localparam int B_PCOUT     = 11;
  localparam int B_MDROUT    = 12;
  localparam int B_ZLOOUT    = 13;
  localparam int B_ZHIOUT    = 14;
  localparam int B_HIOUT     = 15;
  localparam int B_LOOUT     = 16;
  localparam int B_INPORTOUT = 17;
  localparam int B_COUT      = 18;
  localparam int B_ROUT      = 19;
  localparam int B_BAOUT     = 20;
  localparam int B_GRA       = 21;
  localparam int B_GRB       = 22;
  localparam int B_GRC       = 23;
  localparam int B_READ      = 24;
  localparam int B_WRITE     = 25;
  localparam int B_INCPC     = 26;

  state_t      state_r;
  state_t      state_next_s;
  logic [4:0]  opcode_s;
  logic [26:0] strobe_s;
  logic [26:0] gated_s;
  logic [4:0]  alu_op_s;
  logic        long_op_s;
  logic        mem_op_s;
  logic        unused_ir_s;

  assign opcode_s    = IRregister[31:27];
  assign unused_ir_s = ^IRregister[26:0];

  // Instruction classes that steer the T3/T5/T6 branch points.
  always_comb begin
    long_op_s = 1'b0;
    mem_op_s  = 1'b0;
    case (opcode_s)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI, OP_BR: long_op_s = 1'b1;
      OP_LD, OP_ST: begin
        long_op_s = 1'b1;
        mem_op_s  = 1'b1;
      end
      default: long_op_s = 1'b0;
    endcase
  end

  // State register; Reset wins from any state, including HALT.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= T0;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_next_s = T0;
    case (state_r)
      T0: state_next_s = T1;
      T1: state_next_s = T2;
      T2: state_next_s = T3;
      T3: begin
        if (opcode_s == OP_HALT) begin
          state_next_s = HALT;
        end else if (long_op_s) begin
          state_next_s = T4;
        end else begin
          state_next_s = T0;
        end
      end
      T4: state_next_s = T5;
      T5: begin
        if (mem_op_s || (opcode_s == OP_BR)) begin
          state_next_s = T6;
        end else begin
          state_next_s = T0;
        end
      end
      T6: begin
        if (mem_op_s) begin
          state_next_s = T7;
        end else begin
          state_next_s = T0;
        end
      end
      T7:      state_next_s = T0;
      HALT:    state_next_s = HALT;
      default: state_next_s = T0;
    endcase
  end

  // Moore strobe decode; only the br T6 step also looks at CON.
  always_comb begin
    strobe_s = 27'd0;
    alu_op_s = 5'b00000;
    case (state_r)
      T0: begin
        strobe_s[B_PCOUT] = 1'b1;
        strobe_s[B_MARIN] = 1'b1;
        strobe_s[B_INCPC] = 1'b1;
        strobe_s[B_ZIN]   = 1'b1;
      end
      T1: begin
        strobe_s[B_ZLOOUT] = 1'b1;
        strobe_s[B_PCIN]   = 1'b1;
        strobe_s[B_READ]   = 1'b1;
        strobe_s[B_MDRIN]  = 1'b1;
      end
      T2: begin
        strobe_s[B_MDROUT] = 1'b1;
        strobe_s[B_IRIN]   = 1'b1;
      end
      T3: begin
        case (opcode_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            strobe_s[B_GRB]  = 1'b1;
            strobe_s[B_ROUT] = 1'b1;
            strobe_s[B_YIN]  = 1'b1;
          end
          OP_LDI, OP_LD, OP_ST: begin
            strobe_s[B_GRB]   = 1'b1;
            strobe_s[B_BAOUT] = 1'b1;
            strobe_s[B_YIN]   = 1'b1;
          end
          OP_BR: begin
            strobe_s[B_GRA]   = 1'b1;
            strobe_s[B_ROUT]  = 1'b1;
            strobe_s[B_CONIN] = 1'b1;
          end
          OP_JR: begin
            strobe_s[B_GRA]  = 1'b1;
            strobe_s[B_ROUT] = 1'b1;
            strobe_s[B_PCIN] = 1'b1;
          end
          OP_IN: begin
            strobe_s[B_INPORTOUT] = 1'b1;
            strobe_s[B_GRA]       = 1'b1;
            strobe_s[B_RIN]       = 1'b1;
          end
          OP_OUT: begin
            strobe_s[B_GRA]       = 1'b1;
            strobe_s[B_ROUT]      = 1'b1;
            strobe_s[B_OUTPORTIN] = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        case (opcode_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            strobe_s[B_GRC]  = 1'b1;
            strobe_s[B_ROUT] = 1'b1;
            strobe_s[B_ZIN]  = 1'b1;
            alu_op_s         = opcode_s;
          end
          OP_ADDI, OP_LDI, OP_LD, OP_ST: begin
            strobe_s[B_COUT] = 1'b1;
            strobe_s[B_ZIN]  = 1'b1;
            alu_op_s         = ADD_OP;
          end
          OP_BR: begin
            strobe_s[B_PCOUT] = 1'b1;
            strobe_s[B_YIN]   = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (opcode_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: begin
            strobe_s[B_ZLOOUT] = 1'b1;
            strobe_s[B_GRA]    = 1'b1;
            strobe_s[B_RIN]    = 1'b1;
          end
          OP_LD, OP_ST: begin
            strobe_s[B_ZLOOUT] = 1'b1;
            strobe_s[B_MARIN]  = 1'b1;
          end
          OP_BR: begin
            strobe_s[B_COUT] = 1'b1;
            strobe_s[B_ZIN]  = 1'b1;
            alu_op_s         = ADD_OP;
          end
          default: ;
        endcase
      end
      T6: begin
        case (opcode_s)
          OP_LD: begin
            strobe_s[B_READ]  = 1'b1;
            strobe_s[B_MDRIN] = 1'b1;
          end
          OP_ST: begin
            strobe_s[B_GRA]   = 1'b1;
            strobe_s[B_ROUT]  = 1'b1;
            strobe_s[B_MDRIN] = 1'b1;
          end
          OP_BR: begin
            if (CON) begin
              strobe_s[B_ZLOOUT] = 1'b1;
              strobe_s[B_PCIN]   = 1'b1;
            end else begin
              strobe_s[B_PCIN] = 1'b0;
            end
          end
          default: ;
        endcase
      end
      T7: begin
        case (opcode_s)
          OP_LD: begin
            strobe_s[B_MDROUT] = 1'b1;
            strobe_s[B_GRA]    = 1'b1;
            strobe_s[B_RIN]    = 1'b1;
          end
          OP_ST:   strobe_s[B_WRITE] = 1'b1;
          default: ;
        endcase
      end
      HALT:    strobe_s = 27'd0;
      default: strobe_s = 27'd0;
    endcase
  end

  // Reset suppresses every strobe immediately, without waiting for an edge.
  assign gated_s = strobe_s & {27{~Reset}};
  assign AluOp   = Reset ? 5'b00000 : alu_op_s;
  assign Run     = Reset | (state_r != HALT);

  assign PCin      = gated_s[B_PCIN];
  assign MDRin     = gated_s[B_MDRIN];
  assign Zin       = gated_s[B_ZIN];
  assign Yin       = gated_s[B_YIN];
  assign MARin     = gated_s[B_MARIN];
  assign IRin      = gated_s[B_IRIN];
  assign CONin     = gated_s[B_CONIN];
  assign Rin       = gated_s[B_RIN];
  assign HIin      = gated_s[B_HIIN];
  assign LOin      = gated_s[B_LOIN];
  assign OUTPORTin = gated_s[B_OUTPORTIN];
  assign PCout     = gated_s[B_PCOUT];
  assign MDRout    = gated_s[B_MDROUT];
  assign ZLOout    = gated_s[B_ZLOOUT];
  assign ZHIout    = gated_s[B_ZHIOUT];
  assign HIout     = gated_s[B_HIOUT];
  assign LOout     = gated_s[B_LOOUT];
  assign INPORTout = gated_s[B_INPORTOUT];
  assign Cout      = gated_s[B_COUT];
  assign Rout      = gated_s[B_ROUT];
  assign BAout     = gated_s[B_BAOUT];
  assign Gra       = gated_s[B_GRA];
  assign Grb       = gated_s[B_GRB];
  assign Grc       = gated_s[B_GRC];
  assign Read      = gated_s[B_READ];
  assign write     = gated_s[B_WRITE];
  assign IncPC     = gated_s[B_INCPC];

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: each instruction is expanded into a per-cycle
// list of expected strobe sets and compared cycle by cycle at the falling edge.
module tb_control_unit;

  logic        Clock;
  logic        Reset;
  logic [31:0] IRregister;
  logic        CON;
  logic PCin, MDRin, Zin, Yin, MARin, IRin, CONin, Rin, HIin, LOin, OUTPORTin;
  logic PCout, MDRout, ZLOout, ZHIout, HIout, LOout, INPORTout, Cout, Rout, BAout;
  logic Gra, Grb, Grc, Read, write, IncPC;
  logic [4:0] AluOp;
  logic       Run;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .IRregister(IRregister), .CON(CON),
    .PCin(PCin), .MDRin(MDRin), .Zin(Zin), .Yin(Yin), .MARin(MARin), .IRin(IRin),
    .CONin(CONin), .Rin(Rin), .HIin(HIin), .LOin(LOin), .OUTPORTin(OUTPORTin),
    .PCout(PCout), .MDRout(MDRout), .ZLOout(ZLOout), .ZHIout(ZHIout), .HIout(HIout),
    .LOout(LOout), .INPORTout(INPORTout), .Cout(Cout), .Rout(Rout), .BAout(BAout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .write(write), .IncPC(IncPC),
    .AluOp(AluOp), .Run(Run)
  );

  localparam logic [26:0] M_PCIN      = 27'd1 << 0;
  localparam logic [26:0] M_MDRIN     = 27'd1 << 1;
  localparam logic [26:0] M_ZIN       = 27'd1 << 2;
  localparam logic [26:0] M_YIN       = 27'd1 << 3;
  localparam logic [26:0] M_MARIN     = 27'd1 << 4;
  localparam logic [26:0] M_IRIN      = 27'd1 << 5;
  localparam logic [26:0] M_CONIN     = 27'd1 << 6;
  localparam logic [26:0] M_RIN       = 27'd1 << 7;
  localparam logic [26:0] M_OUTPORTIN = 27'd1 << 10;
  localparam logic [26:0] M_PCOUT     = 27'd1 << 11;
  localparam logic [26:0] M_MDROUT    = 27'd1 << 12;
  localparam logic [26:0] M_ZLOOUT    = 27'd1 << 13;
  localparam logic [26:0] M_INPORTOUT = 27'd1 << 17;
  localparam logic [26:0] M_COUT      = 27'd1 << 18;
  localparam logic [26:0] M_ROUT      = 27'd1 << 19;
  localparam logic [26:0] M_BAOUT     = 27'd1 << 20;
  localparam logic [26:0] M_GRA       = 27'd1 << 21;
  localparam logic [26:0] M_GRB       = 27'd1 << 22;
  localparam logic [26:0] M_GRC       = 27'd1 << 23;
  localparam logic [26:0] M_READ      = 27'd1 << 24;
  localparam logic [26:0] M_WRITE     = 27'd1 << 25;
  localparam logic [26:0] M_INCPC     = 27'd1 << 26;
  localparam logic [26:0] M_BUS       = 27'h01FF800;
  localparam logic [4:0]  ADD_CODE    = 5'b00011;

  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b01010;
  localparam logic [4:0] OP_OR = 5'b01011, OP_ADDI = 5'b01100, OP_BR = 5'b10011;
  localparam logic [4:0] OP_JR = 5'b10100, OP_IN = 5'b10110, OP_OUT = 5'b10111;
  localparam logic [4:0] OP_NOP = 5'b11010, OP_HALT = 5'b11011;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_value(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] observed();
    return {Run, AluOp, IncPC, write, Read, Grc, Grb, Gra, BAout, Rout, Cout, INPORTout,
            LOout, HIout, ZHIout, ZLOout, MDRout, PCout, OUTPORTin, LOin, HIin, Rin,
            CONin, IRin, MARin, Yin, Zin, MDRin, PCin};
  endfunction

  task automatic push_cycle(input logic [26:0] m, input logic [4:0] alu, input logic run);
    exp_q.push_back({run, alu, m});
  endtask

  // Reference microprogram: the strobe list of every cycle of one instruction.
  task automatic build_seq(input logic [4:0] op, input bit con);
    exp_q.delete();
    push_cycle(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0, 1'b1);
    push_cycle(M_ZLOOUT | M_PCIN | M_READ | M_MDRIN, 5'd0, 1'b1);
    push_cycle(M_MDROUT | M_IRIN, 5'd0, 1'b1);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        push_cycle(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1);
        push_cycle(M_GRC | M_ROUT | M_ZIN, op, 1'b1);
        push_cycle(M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1'b1);
      end
      OP_ADDI, OP_LDI: begin
        push_cycle(M_GRB | ((op == OP_LDI) ? M_BAOUT : M_ROUT) | M_YIN, 5'd0, 1'b1);
        push_cycle(M_COUT | M_ZIN, ADD_CODE, 1'b1);
        push_cycle(M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1'b1);
      end
      OP_LD, OP_ST: begin
        push_cycle(M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b1);
        push_cycle(M_COUT | M_ZIN, ADD_CODE, 1'b1);
        push_cycle(M_ZLOOUT | M_MARIN, 5'd0, 1'b1);
        if (op == OP_LD) begin
          push_cycle(M_READ | M_MDRIN, 5'd0, 1'b1);
          push_cycle(M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b1);
        end else begin
          push_cycle(M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b1);
          push_cycle(M_WRITE, 5'd0, 1'b1);
        end
      end
      OP_BR: begin
        push_cycle(M_GRA | M_ROUT | M_CONIN, 5'd0, 1'b1);
        push_cycle(M_PCOUT | M_YIN, 5'd0, 1'b1);
        push_cycle(M_COUT | M_ZIN, ADD_CODE, 1'b1);
        push_cycle(con ? (M_ZLOOUT | M_PCIN) : 27'd0, 5'd0, 1'b1);
      end
      OP_JR:  push_cycle(M_GRA | M_ROUT | M_PCIN, 5'd0, 1'b1);
      OP_IN:  push_cycle(M_INPORTOUT | M_GRA | M_RIN, 5'd0, 1'b1);
      OP_OUT: push_cycle(M_GRA | M_ROUT | M_OUTPORTIN, 5'd0, 1'b1);
      OP_HALT: begin
        push_cycle(27'd0, 5'd0, 1'b1);
        for (int k = 0; k < 20; k++) push_cycle(27'd0, 5'd0, 1'b0);
      end
      default: push_cycle(27'd0, 5'd0, 1'b1);
    endcase
  endtask

  function automatic bit is_defined(input logic [4:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
      OP_BR, OP_JR, OP_IN, OP_OUT, OP_NOP, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Entered at a falling edge with the DUT in T0; leaves at the falling edge after the
  // last expected cycle. A non-negative stop_at raises Reset in that cycle instead.
  task automatic run_instr(input logic [4:0] op, input bit con, input int stop_at);
    logic [31:0] rnd;
    logic [32:0] obs;
    build_seq(op, con);
    rnd        = $urandom();
    IRregister = {op, rnd[26:0]};
    CON        = con;
    foreach (exp_q[i]) begin
      if (i == stop_at) begin
        Reset = 1'b1;
        #1;
        check_value($sformatf("rst_in_op%b_c%0d", op, i), observed(), 33'h100000000);
        @(negedge Clock);
        Reset = 1'b0;
        return;
      end
      #1;
      obs = observed();
      check_value($sformatf("op%b_c%0d", op, i), obs, exp_q[i]);
      check_value($sformatf("bus_onehot_op%b_c%0d", op, i),
                  33'($countones(obs[26:0] & M_BUS) <= 1), 33'd1);
      @(negedge Clock);
    end
  endtask

  initial begin
    logic [4:0] op;
    Reset      = 1'b1;
    IRregister = 32'h0;
    CON        = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      #1;
      check_value("reset_idle", observed(), 33'h100000000);
    end
    @(negedge Clock);
    Reset = 1'b0;

    run_instr(OP_ADD, 1'b0, -1);
    run_instr(OP_LD, 1'b0, -1);
    run_instr(OP_BR, 1'b1, -1);
    run_instr(OP_BR, 1'b0, -1);
    run_instr(OP_JR, 1'b1, -1);
    run_instr(OP_IN, 1'b0, -1);
    run_instr(OP_OUT, 1'b0, -1);
    run_instr(OP_NOP, 1'b0, -1);
    run_instr(5'b11111, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 13))
        0: op = OP_LD;   1: op = OP_LDI;  2: op = OP_ST;  3: op = OP_ADD;
        4: op = OP_SUB;  5: op = OP_AND;  6: op = OP_OR;  7: op = OP_ADDI;
        8: op = OP_BR;   9: op = OP_JR;  10: op = OP_IN; 11: op = OP_OUT;
        12: op = OP_NOP;
        default: begin
          op = 5'($urandom_range(0, 31));
          while (is_defined(op)) op = 5'($urandom_range(0, 31));
        end
      endcase
      run_instr(op, 1'($urandom_range(0, 1)), -1);
    end

    run_instr(OP_ST, 1'b0, 6);
    run_instr(OP_ST, 1'b0, -1);
    run_instr(OP_ADD, 1'b0, 4);
    run_instr(OP_SUB, 1'b0, -1);

    run_instr(OP_HALT, 1'b0, -1);
    Reset = 1'b1;
    #1;
    check_value("halt_reset_active", observed(), 33'h100000000);
    @(negedge Clock);
    Reset = 1'b0;
    run_instr(OP_ADDI, 1'b0, -1);
    run_instr(OP_LDI, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter ADD_OP, default 5'b00011; ALU operation code driven on AluOp for address/offset arithmetic.
REQ-002 Clock  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 IRregister  input  32  instruction word; opcode = IRregister[31:27].
REQ-005 CON  input  1  branch-condition flag from datapath CON logic.
REQ-006 Register-enable strobes  output  1 each  PCin, MDRin, Zin, Yin, MARin, IRin, CONin, Rin, HIin, LOin, OUTPORTin.
REQ-007 Bus-source strobes  output  1 each  PCout, MDRout, ZLOout, ZHIout, HIout, LOout, INPORTout, Cout, Rout, BAout.
REQ-008 Field selects  output  1 each  Gra, Grb, Grc.
REQ-009 Memory/PC strobes  output  1 each  Read, write, IncPC.
REQ-010 AluOp  output  5  ALU operation select.
REQ-011 Run  output  1  high while executing; low in HALT.

Function
REQ-012 The block SHALL be a Moore FSM with states T0..T7 and HALT; each state lasts exactly one clock; outputs are registered-decoded from state and held for the whole cycle.
REQ-013 Any strobe not listed for a state SHALL be 0; AluOp SHALL be 0 except where listed.
REQ-014 Fetch SHALL be T0: PCout, MARin, IncPC, Zin; T1: ZLOout, PCin, Read, MDRin; T2: MDRout, IRin; then T3.
REQ-015 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 01010, or 01011, addi 01100, br 10011, jr 10100, in 10110, out 10111, nop 11010, halt 11011.
REQ-016 add/sub/and/or: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin, AluOp=opcode; T5 ZLOout,Gra,Rin; then T0.
REQ-017 addi: T3 Grb,Rout,Yin; T4 Cout,Zin, AluOp=ADD_OP; T5 ZLOout,Gra,Rin; then T0.
REQ-018 ldi: as addi but T3 uses BAout instead of Rout.
REQ-019 ld: T3 Grb,BAout,Yin; T4 Cout,Zin, AluOp=ADD_OP; T5 ZLOout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin; then T0.
REQ-020 st: T3-T5 as ld; T6 Gra,Rout,MDRin (Read=0); T7 write; then T0.
REQ-021 br: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,Zin, AluOp=ADD_OP; T6 ZLOout,PCin only if CON=1 sampled in T6, else no strobes; then T0.
REQ-022 jr: T3 Gra,Rout,PCin; then T0.
REQ-023 in: T3 INPORTout,Gra,Rin; then T0. out: T3 Gra,Rout,OUTPORTin; then T0.
REQ-024 nop and every undefined opcode SHALL go T2 -> T0 via T3 with no strobes asserted in T3.
REQ-025 halt: T3 -> HALT; HALT SHALL assert no strobes, Run=0, and persist until Reset.
REQ-026 Opcode SHALL be decoded from IRregister during T3..T7; IR changes are not expected outside T2.
REQ-027 Never SHALL two bus-source strobes be high in the same cycle.

Reset
REQ-028 Reset high at a rising edge SHALL force state T0 on that edge from any state, including mid-instruction and HALT.
REQ-029 While Reset is high, all strobes and AluOp SHALL be 0 and Run SHALL be 1; first cycle after Reset deasserts is T0 with fetch strobes active.

Verification
REQ-030 Reset then IR=add (0x18000000 | Ra/Rb/Rc fields) -> T0..T5 strobes per REQ-014/016, AluOp=00011 in T4, back to T0 at cycle 6.
REQ-031 IR=ld -> eight-cycle instruction; Read high in T1 and T6 only; Gra,Rin in T7.
REQ-032 IR=br with CON=1 -> PCin,ZLOout in T6; repeat with CON=0 -> no strobes in T6; both return to T0.
REQ-033 IR=jr -> Gra,Rout,PCin in T3 only; instruction length 4 cycles.
REQ-034 IR=halt -> Run=0 from T3+1, all strobes 0 for 20 cycles; Reset pulse -> T0 next cycle, Run=1.
REQ-035 Reset asserted during st T6 -> write never asserted; T0 follows; checker confirms one-hot bus-source rule every cycle.
